// File: rtl/score_keeper_if.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper_if
//  Purpose  : Bundles the scoreboard's frame/goal/match-control inputs and its
//             display, hold and result outputs into one interface.
//  Ports    : master - ball/timing logic side (drives ticks and goals,
//                      reads the digits and status)
//             slave  - score_keeper side
//  Revision : 1.0 - initial release
// ============================================================================
interface score_keeper_if;
    logic       frame_tick;   // one-cycle pulse at start of vertical blank
    logic       goal_left;    // level; rising edge = one left-player goal
    logic       goal_right;   // level; rising edge = one right-player goal
    logic       new_game;     // one-cycle pulse: restart match
    logic [3:0] l_tens;       // displayed left tens digit (BCD)
    logic [3:0] l_units;      // displayed left units digit (BCD)
    logic [3:0] r_tens;       // displayed right tens digit (BCD)
    logic [3:0] r_units;      // displayed right units digit (BCD)
    logic       ball_hold;    // ball frozen at centre
    logic       game_over;    // match finished
    logic [1:0] winner;       // 01 left, 10 right, 11 tie, 00 none

    modport master (
        output frame_tick, goal_left, goal_right, new_game,
        input  l_tens, l_units, r_tens, r_units, ball_hold, game_over, winner
    );

    modport slave (
        input  frame_tick, goal_left, goal_right, new_game,
        output l_tens, l_units, r_tens, r_units, ball_hold, game_over, winner
    );
endinterface
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Purpose  : Pong scoreboard. Counts goals per player in two-digit BCD,
//             publishes the digits to the 7-segment overlay only on
//             frame_tick, and sequences the serve delay / game-over hold.
//  Ports    : px_clk - pixel clock, all logic on its rising edge
//             reset  - asynchronous active-high reset
//             sb     - score_keeper_if.slave (frame_tick, goal_left,
//                      goal_right, new_game in; l_tens, l_units, r_tens,
//                      r_units, ball_hold, game_over, winner out)
//  Params   : MAX_SCORE   - winning score, 1..99
//             HOLD_FRAMES - serve-delay length in frames, 1..255
//  Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int MAX_SCORE   = 11,
    parameter int HOLD_FRAMES = 60
) (
    input  wire            px_clk,
    input  wire            reset,
    score_keeper_if.slave  sb
);

    localparam logic [1:0] c_ST_HOLD   = 2'd0;
    localparam logic [1:0] c_ST_PLAY   = 2'd1;
    localparam logic [1:0] c_ST_OVER   = 2'd2;

    localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD_FRAMES);
    localparam logic [3:0] c_MAX_TENS  = 4'(MAX_SCORE / 10);
    localparam logic [3:0] c_MAX_UNITS = 4'(MAX_SCORE % 10);

    // BCD increment of a two-digit score; 99 saturates.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                           input logic [3:0] units);
        logic [7:0] res;
        if (units == 4'd9) begin
            if (tens == 4'd9) res = {tens, units};
            else              res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, units + 4'd1};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       goal_l_q, goal_r_q;
    logic [7:0] l_score_q, l_score_d;   // {tens, units}
    logic [7:0] r_score_q, r_score_d;
    logic [7:0] l_disp_q, l_disp_d;
    logic [7:0] r_disp_q, r_disp_d;
    logic [1:0] winner_q, winner_d;

    // ------------------------------------------------------------------
    // Goal edge detection and scoring arithmetic
    // ------------------------------------------------------------------
    logic       ev_l, ev_r, playing, scoring;
    logic [7:0] l_inc, r_inc;
    logic       hit_l, hit_r;

    assign ev_l    = sb.goal_left  & ~goal_l_q;
    assign ev_r    = sb.goal_right & ~goal_r_q;
    assign playing = (state_q == c_ST_PLAY);
    assign scoring = playing & (ev_l | ev_r);
    assign l_inc   = bcd_inc(l_score_q[7:4], l_score_q[3:0]);
    assign r_inc   = bcd_inc(r_score_q[7:4], r_score_q[3:0]);
    // A player only reaches MAX_SCORE by scoring on this very event.
    assign hit_l   = playing & ev_l & (l_inc == {c_MAX_TENS, c_MAX_UNITS});
    assign hit_r   = playing & ev_r & (r_inc == {c_MAX_TENS, c_MAX_UNITS});

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state_q   <= c_ST_HOLD;
            cnt_q     <= c_HOLD_LOAD;
            goal_l_q  <= 1'b0;
            goal_r_q  <= 1'b0;
            l_score_q <= 8'h00;
            r_score_q <= 8'h00;
            l_disp_q  <= 8'h00;
            r_disp_q  <= 8'h00;
            winner_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Edge registers sample in every state, including across new_game,
            // so a level that stays high never produces a later event.
            goal_l_q  <= sb.goal_left;
            goal_r_q  <= sb.goal_right;
            l_score_q <= l_score_d;
            r_score_q <= r_score_d;
            l_disp_q  <= l_disp_d;
            r_disp_q  <= r_disp_d;
            winner_q  <= winner_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (sb.new_game) begin
            state_d = c_ST_HOLD;
        end else begin
            case (state_q)
                c_ST_HOLD: if (sb.frame_tick && cnt_q == 8'd1) state_d = c_ST_PLAY;
                c_ST_PLAY: if (ev_l || ev_r) state_d = (hit_l || hit_r) ? c_ST_OVER : c_ST_HOLD;
                c_ST_OVER: state_d = c_ST_OVER;
                default:   state_d = c_ST_HOLD;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath next values (counter, scores, display, winner)
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        l_disp_d  = l_disp_q;
        r_disp_d  = r_disp_q;
        winner_d  = winner_q;

        if (sb.new_game) begin
            cnt_d     = c_HOLD_LOAD;
            l_score_d = 8'h00;
            r_score_d = 8'h00;
            l_disp_d  = 8'h00;
            r_disp_d  = 8'h00;
            winner_d  = 2'b00;
        end else begin
            if (state_q == c_ST_HOLD && sb.frame_tick && cnt_q != 8'd1)
                cnt_d = cnt_q - 8'd1;
            else if (scoring)
                cnt_d = c_HOLD_LOAD;   // reload for the coming serve delay

            if (playing && ev_l) l_score_d = l_inc;
            if (playing && ev_r) r_score_d = r_inc;

            // Display takes the pre-increment score, so a goal coinciding
            // with the tick shows up one frame later.
            if (sb.frame_tick) begin
                l_disp_d = l_score_q;
                r_disp_d = r_score_q;
            end

            if (hit_l || hit_r) winner_d = {hit_r, hit_l};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        sb.ball_hold = (state_q != c_ST_PLAY);
        sb.game_over = (state_q == c_ST_OVER);
        sb.winner    = winner_q;
        sb.l_tens    = l_disp_q[7:4];
        sb.l_units   = l_disp_q[3:0];
        sb.r_tens    = r_disp_q[7:4];
        sb.r_units   = r_disp_q[3:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_keeper
//  Purpose  : Directed self-checking bench for score_keeper with
//             MAX_SCORE=11 and HOLD_FRAMES=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    logic px_clk = 1'b0;
    logic reset  = 1'b1;
    int   n_cmp  = 0;
    int   n_err  = 0;

    score_keeper_if sb ();

    score_keeper #(
        .MAX_SCORE   (11),
        .HOLD_FRAMES (3)
    ) dut (
        .px_clk (px_clk),
        .reset  (reset),
        .sb     (sb.slave)
    );

    always #5 px_clk = ~px_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic frame();
        sb.frame_tick = 1'b1;
        tick();
        sb.frame_tick = 1'b0;
    endtask

    // One goal from PLAY, then ride out the serve delay back into PLAY.
    task automatic score_left();
        sb.goal_left = 1'b1;
        tick();
        sb.goal_left = 1'b0;
        tick();
        repeat (3) frame();
    endtask

    task automatic score_right();
        sb.goal_right = 1'b1;
        tick();
        sb.goal_right = 1'b0;
        tick();
        repeat (3) frame();
    endtask

    task automatic chk_digits(input string tag, input int lt, input int lu,
                              input int rt, input int ru);
        chk({tag, ".l_tens"},  int'(sb.l_tens),  lt);
        chk({tag, ".l_units"}, int'(sb.l_units), lu);
        chk({tag, ".r_tens"},  int'(sb.r_tens),  rt);
        chk({tag, ".r_units"}, int'(sb.r_units), ru);
    endtask

    initial begin
        sb.frame_tick = 1'b0;
        sb.goal_left  = 1'b0;
        sb.goal_right = 1'b0;
        sb.new_game   = 1'b0;

        // ---------------- 1: reset and initial serve delay ----------------
        tick();
        tick();
        chk_digits("rst", 0, 0, 0, 0);
        chk("rst.ball_hold", int'(sb.ball_hold), 1);
        chk("rst.game_over", int'(sb.game_over), 0);
        chk("rst.winner",    int'(sb.winner),    0);
        reset = 1'b0;
        tick();
        // goal pulse during HOLD must be ignored
        sb.goal_left = 1'b1;
        tick();
        sb.goal_left = 1'b0;
        tick();
        frame();
        frame();
        chk("hold2.ball_hold", int'(sb.ball_hold), 1);
        frame();
        chk("hold3.ball_hold", int'(sb.ball_hold), 0);
        frame();
        chk("hold.ignored_goal", int'(sb.l_units), 0);

        // ---------------- 2: level held 5 cycles scores once ----------------
        sb.goal_left = 1'b1;
        repeat (5) tick();
        sb.goal_left = 1'b0;
        tick();
        chk("g1.l_units_pre",  int'(sb.l_units),   0);
        chk("g1.ball_hold",    int'(sb.ball_hold), 1);
        frame();
        chk("g1.l_units_post", int'(sb.l_units),   1);
        frame();
        chk("g1.hold_f2",      int'(sb.ball_hold), 1);
        frame();
        chk("g1.play",         int'(sb.ball_hold), 0);
        frame();
        chk("g1.once",         int'(sb.l_units),   1);

        // ---------------- 3: BCD carry 09 -> 10 ----------------
        repeat (8) score_left();
        chk_digits("l09", 0, 9, 0, 0);
        score_left();
        chk_digits("l10", 1, 0, 0, 0);

        // ---------------- 4: simultaneous winning goals ----------------
        repeat (10) score_right();
        chk_digits("r10", 1, 0, 1, 0);
        chk("r10.winner", int'(sb.winner), 0);
        // goals coincide with a frame tick: display keeps the old score
        sb.goal_left  = 1'b1;
        sb.goal_right = 1'b1;
        sb.frame_tick = 1'b1;
        tick();
        sb.frame_tick = 1'b0;
        sb.goal_left  = 1'b0;
        sb.goal_right = 1'b0;
        chk_digits("tie.same_tick", 1, 0, 1, 0);
        chk("tie.game_over", int'(sb.game_over), 1);
        chk("tie.ball_hold", int'(sb.ball_hold), 1);
        chk("tie.winner",    int'(sb.winner),    3);
        frame();
        chk_digits("tie.shown", 1, 1, 1, 1);
        // further goals in OVER are ignored
        sb.goal_left = 1'b1;
        tick();
        sb.goal_left = 1'b0;
        sb.goal_right = 1'b1;
        tick();
        sb.goal_right = 1'b0;
        tick();
        frame();
        chk_digits("tie.frozen", 1, 1, 1, 1);
        chk("tie.winner_held", int'(sb.winner), 3);

        // ---------------- 5: right wins, then new_game with goal level high ----
        sb.new_game = 1'b1;
        tick();
        sb.new_game = 1'b0;
        chk_digits("ng1", 0, 0, 0, 0);
        chk("ng1.winner", int'(sb.winner), 0);
        repeat (3) frame();
        repeat (11) score_right();
        chk_digits("r11", 0, 0, 1, 1);
        chk("r11.winner",    int'(sb.winner),    2);
        chk("r11.game_over", int'(sb.game_over), 1);
        sb.goal_left = 1'b1;
        tick();
        sb.new_game = 1'b1;
        tick();
        sb.new_game = 1'b0;
        chk_digits("ng2", 0, 0, 0, 0);
        chk("ng2.winner",    int'(sb.winner),    0);
        chk("ng2.game_over", int'(sb.game_over), 0);
        chk("ng2.ball_hold", int'(sb.ball_hold), 1);
        repeat (3) frame();
        chk("ng2.play", int'(sb.ball_hold), 0);
        sb.goal_left = 1'b0;
        tick();
        frame();
        chk("ng2.no_point", int'(sb.l_units),   0);
        chk("ng2.still_play", int'(sb.ball_hold), 0);

        // ---------------- 6: asynchronous reset mid-play at 05-03 ----------
        repeat (5) score_left();
        repeat (3) score_right();
        frame();
        chk_digits("s0503", 0, 5, 0, 3);
        chk("s0503.ball_hold", int'(sb.ball_hold), 0);
        #1;
        reset = 1'b1;
        #1;   // still well before the next rising edge
        chk_digits("arst", 0, 0, 0, 0);
        chk("arst.ball_hold", int'(sb.ball_hold), 1);
        chk("arst.game_over", int'(sb.game_over), 0);
        chk("arst.winner",    int'(sb.winner),    0);
        tick();
        reset = 1'b0;
        tick();
        frame();
        chk_digits("arst.cleared", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
